// File: rtl/serial_tx_8bit_if.sv
// Byte handshake between a producer and the serializer.
// Master drives data/valid; the serializer answers with ready.
interface serial_tx_8bit_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx_8bit.sv
// Byte-to-serial frame transmitter: start, 8 data LSB first, optional even parity, stop.
// Line changes 1 cycle after acceptance; ready only in IDLE, valid while busy is dropped.
module serial_tx_8bit #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  serial_tx_8bit_if.slave  s_if,
  output logic             tx,
  output logic             tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             last;
  logic             accept;

  assign s_if.tx_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = s_if.tx_valid && s_if.tx_ready;
  assign last          = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    // Divider wraps on every bit boundary, so each state only reacts to `last`.
    if (state_q != ST_IDLE) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          shreg_d = s_if.tx_data;
          par_d   = ^s_if.tx_data;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (last) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (last) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (last) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (last) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_serial_tx_8bit.sv
// Scoreboard bench for three serializer configurations: (C=4), (C=4, parity), (C=2).
// Expected frames are hand-written level strings in line order, start bit first.
module tb_serial_tx_8bit;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] vld;
  logic [7:0] dat [3];
  logic [2:0] rdy;
  logic [2:0] txl;
  logic [2:0] busy;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  localparam int CP [3] = '{4, 4, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx_8bit_if if0 ();
  serial_tx_8bit_if if1 ();
  serial_tx_8bit_if if2 ();

  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if0.tx_data  = dat[0];
  assign if1.tx_data  = dat[1];
  assign if2.tx_data  = dat[2];
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;

  serial_tx_8bit #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .s_if(if0), .tx(txl[0]), .tx_busy(busy[0]));
  serial_tx_8bit #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .s_if(if1), .tx(txl[1]), .tx_busy(busy[1]));
  serial_tx_8bit #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .s_if(if2), .tx(txl[2]), .tx_busy(busy[2]));

  // Scoreboard: one entry per accepted byte.
  int    exp_id_q [$];
  string exp_bits_q [$];

  // Monitor state per DUT.
  int    act  [3] = '{0, 0, 0};
  int    post [3] = '{0, 0, 0};
  int    pos  [3] = '{0, 0, 0};
  string cur_bits [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        act[i]  = 0;
        post[i] = 0;
      end else if (post[i] != 0) begin
        total++;
        if (!(txl[i] == 1'b1 && busy[i] == 1'b0 && rdy[i] == 1'b1)) begin
          bad++;
          $display("FAIL idle_gap dut%0d: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=1",
                   i, txl[i], busy[i], rdy[i]);
        end
        post[i] = 0;
      end else begin
        if (act[i] == 0 && txl[i] == 1'b0) begin
          total++;
          if (exp_id_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame dut%0d: frame started with empty scoreboard", i);
          end else begin
            int id;
            id          = exp_id_q.pop_front();
            cur_bits[i] = exp_bits_q.pop_front();
            if (id != i) begin
              bad++;
              $display("FAIL frame_owner: frame on dut%0d, required dut%0d", i, id);
            end
            act[i] = 1;
            pos[i] = 0;
          end
        end
        if (act[i] != 0) begin
          logic lvl;
          lvl = (cur_bits[i].getc(pos[i] / CP[i]) == "1");
          total++;
          if (txl[i] !== lvl || busy[i] !== 1'b1 || rdy[i] !== 1'b0) begin
            bad++;
            $display("FAIL frame_sample dut%0d pos=%0d: tx=%b busy=%b ready=%b, required tx=%b busy=1 ready=0",
                     i, pos[i], txl[i], busy[i], rdy[i], lvl);
          end
          pos[i]++;
          if (pos[i] == cur_bits[i].len() * CP[i]) begin
            act[i]  = 0;
            post[i] = 1;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int a, input int r);
    total++;
    if (a != r) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, a, r);
    end
  endtask

  // Offers a byte; pushes the expected frame just before the accepting edge.
  task automatic send(input int id, input logic [7:0] d, input string f, input bit keep,
                      output int t);
    dat[id] = d;
    vld[id] = 1'b1;
    t = -1;
    for (int n = 0; n < 300; n++) begin
      if (rdy[id]) begin
        exp_id_q.push_back(id);
        exp_bits_q.push_back(f);
        t = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!keep) vld[id] = 1'b0;
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: ready never seen, required acceptance", id);
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    for (n = 0; n < 200; n++) begin
      if (!busy[id]) break;
      @(posedge clk);
      #1;
    end
    if (n == 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d: busy=%b, required 0", id, busy[id]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    rst = 3'b111;
    vld = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_tx_dut%0d", i), int'(txl[i]), 1);
      check($sformatf("reset_busy_dut%0d", i), int'(busy[i]), 0);
      check($sformatf("reset_ready_dut%0d", i), int'(rdy[i]), 0);
    end
    rst = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("ready_after_reset_dut%0d", i), int'(rdy[i]), 1);

    // Single byte 0xA5.
    send(0, 8'hA5, "0101001011", 1'b0, t);
    wait_idle(0);

    // Back-to-back 0x00 then 0xFF with valid held high.
    send(0, 8'h00, "0000000001", 1'b1, t1);
    send(0, 8'hFF, "0111111111", 1'b0, t2);
    check("b2b_spacing", t2 - t1, 41);
    wait_idle(0);

    // Valid pulse and data change mid-frame must not disturb 0x96.
    send(0, 8'h96, "0011010011", 1'b0, t);
    repeat (10) @(posedge clk);
    #1;
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dat[0] = 8'hFF;
    wait_idle(0);
    repeat (20) @(posedge clk);
    #1;
    check("no_queued_frame", exp_id_q.size(), 0);

    // Reset during data bit 3 of 0xF0, then 0x5A.
    send(0, 8'hF0, "0000011111", 1'b0, t);
    repeat (16) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    #1;
    check("rst_ready_low", int'(rdy[0]), 0);
    @(posedge clk);
    #1;
    check("abort_tx", int'(txl[0]), 1);
    check("abort_busy", int'(busy[0]), 0);
    check("abort_ready", int'(rdy[0]), 0);
    rst[0] = 1'b0;
    #1;
    check("abort_ready_release", int'(rdy[0]), 1);
    send(0, 8'h5A, "0010110101", 1'b0, t);
    wait_idle(0);

    // Parity configuration.
    send(1, 8'h07, "01110000011", 1'b0, t);
    wait_idle(1);
    send(1, 8'h03, "01100000001", 1'b0, t);
    wait_idle(1);

    // Minimum divisor.
    send(2, 8'h81, "0100000011", 1'b0, t);
    wait_idle(2);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_id_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
